// File: rtl/at_decoder.sv
// Register-address and hazard-class decoder for the Decode stage.
// Stateless: A1/A2/A3/ic are a pure function of Instr.
module at_decoder (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [31:0] Instr,
    output logic [4:0]  A1,
    output logic [4:0]  A2,
    output logic [4:0]  A3,
    output logic [3:0]  ic
);

    localparam logic [3:0] IC_NONE  = 4'd0;
    localparam logic [3:0] IC_CAL_R = 4'd1;
    localparam logic [3:0] IC_CAL_I = 4'd2;
    localparam logic [3:0] IC_LOAD  = 4'd3;
    localparam logic [3:0] IC_STORE = 4'd4;
    localparam logic [3:0] IC_B     = 4'd5;
    localparam logic [3:0] IC_JR    = 4'd6;
    localparam logic [3:0] IC_JAL   = 4'd7;
    localparam logic [3:0] IC_JALR  = 4'd8;

    localparam logic [4:0] REG_RA   = 5'd31;

    logic [5:0] op;
    logic [5:0] funct;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;

    assign op    = Instr[31:26];
    assign rs    = Instr[25:21];
    assign rt    = Instr[20:16];
    assign rd    = Instr[15:11];
    assign funct = Instr[5:0];

    // Clock, reset and shamt take no part in the decode.
    logic unused_inputs;
    assign unused_inputs = ^{Clk, Reset, Instr[10:6]};

    always_comb begin
        A1 = 5'd0;
        A2 = 5'd0;
        A3 = 5'd0;
        ic = IC_NONE;
        // The all-zero word would otherwise decode as sll $0,$0,0.
        if (Instr != 32'h0000_0000) begin
            case (op)
                6'h00: begin
                    case (funct)
                        6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26,
                        6'h27, 6'h2A, 6'h2B, 6'h04, 6'h06, 6'h07: begin
                            ic = IC_CAL_R;
                            A1 = rs;
                            A2 = rt;
                            A3 = rd;
                        end
                        6'h00, 6'h02, 6'h03: begin
                            ic = IC_CAL_R;
                            A2 = rt;
                            A3 = rd;
                        end
                        6'h08: begin
                            ic = IC_JR;
                            A1 = rs;
                        end
                        6'h09: begin
                            ic = IC_JALR;
                            A1 = rs;
                            A3 = rd;
                        end
                        default: ;
                    endcase
                end
                6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E: begin
                    ic = IC_CAL_I;
                    A1 = rs;
                    A3 = rt;
                end
                6'h0F: begin
                    ic = IC_CAL_I;
                    A3 = rt;
                end
                6'h20, 6'h21, 6'h23, 6'h24, 6'h25: begin
                    ic = IC_LOAD;
                    A1 = rs;
                    A3 = rt;
                end
                6'h28, 6'h29, 6'h2B: begin
                    ic = IC_STORE;
                    A1 = rs;
                    A2 = rt;
                end
                6'h04, 6'h05: begin
                    ic = IC_B;
                    A1 = rs;
                    A2 = rt;
                end
                6'h06, 6'h07: begin
                    ic = IC_B;
                    A1 = rs;
                end
                // REGIMM: only bltz/bgez are recognised.
                6'h01: begin
                    if (rt == 5'd0 || rt == 5'd1) begin
                        ic = IC_B;
                        A1 = rs;
                    end
                end
                6'h03: begin
                    ic = IC_JAL;
                    A3 = REG_RA;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_at_decoder.sv
// Bench for at_decoder: directed vectors, reset/clock independence, and
// randomized instructions checked against a set-membership reference model.
module tb_at_decoder;

    logic        Clk;
    logic        Reset;
    logic [31:0] Instr;
    logic [4:0]  A1;
    logic [4:0]  A2;
    logic [4:0]  A3;
    logic [3:0]  ic;

    int errors;
    int checks;

    at_decoder dut (
        .Clk   (Clk),
        .Reset (Reset),
        .Instr (Instr),
        .A1    (A1),
        .A2    (A2),
        .A3    (A3),
        .ic    (ic)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [18:0] got, input logic [18:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got A1=%0d A2=%0d A3=%0d ic=%0d, expected A1=%0d A2=%0d A3=%0d ic=%0d",
                     tag, got[18:14], got[13:9], got[8:4], got[3:0],
                     exp[18:14], exp[13:9], exp[8:4], exp[3:0]);
        end
    endtask

    function automatic logic [18:0] pack(input int a1, input int a2, input int a3, input int c);
        logic [4:0] p1;
        logic [4:0] p2;
        logic [4:0] p3;
        logic [3:0] pc;
        p1 = a1[4:0];
        p2 = a2[4:0];
        p3 = a3[4:0];
        pc = c[3:0];
        return {p1, p2, p3, pc};
    endfunction

    // Reference model: classifies by membership in the opcode/funct sets.
    function automatic logic [18:0] ref_decode(input logic [31:0] w);
        int op;
        int fn;
        int rs;
        int rt;
        int rd;
        op = int'(w[31:26]);
        fn = int'(w[5:0]);
        rs = int'(w[25:21]);
        rt = int'(w[20:16]);
        rd = int'(w[15:11]);
        if (w == 32'h0) return pack(0, 0, 0, 0);
        if (op == 0) begin
            if (fn inside {'h20, 'h21, 'h22, 'h23, 'h24, 'h25, 'h26, 'h27, 'h2A, 'h2B, 'h04, 'h06, 'h07})
                return pack(rs, rt, rd, 1);
            if (fn inside {'h00, 'h02, 'h03}) return pack(0, rt, rd, 1);
            if (fn == 'h08) return pack(rs, 0, 0, 6);
            if (fn == 'h09) return pack(rs, 0, rd, 8);
            return pack(0, 0, 0, 0);
        end
        if (op inside {'h08, 'h09, 'h0A, 'h0B, 'h0C, 'h0D, 'h0E}) return pack(rs, 0, rt, 2);
        if (op == 'h0F) return pack(0, 0, rt, 2);
        if (op inside {'h20, 'h21, 'h23, 'h24, 'h25}) return pack(rs, 0, rt, 3);
        if (op inside {'h28, 'h29, 'h2B}) return pack(rs, rt, 0, 4);
        if (op inside {'h04, 'h05}) return pack(rs, rt, 0, 5);
        if (op inside {'h06, 'h07}) return pack(rs, 0, 0, 5);
        if (op == 'h01 && rt <= 1) return pack(rs, 0, 0, 5);
        if (op == 'h03) return pack(0, 0, 31, 7);
        return pack(0, 0, 0, 0);
    endfunction

    task automatic apply_check(input string tag, input logic [31:0] w, input logic [18:0] exp);
        @(negedge Clk);
        Instr = w;
        #1;
        check(tag, {A1, A2, A3, ic}, exp);
    endtask

    int op_pool[30] = '{'h00, 'h00, 'h00, 'h01, 'h01, 'h02, 'h03, 'h04, 'h05, 'h06,
                        'h07, 'h08, 'h09, 'h0A, 'h0B, 'h0C, 'h0D, 'h0E, 'h0F, 'h20,
                        'h21, 'h23, 'h24, 'h25, 'h28, 'h29, 'h2B, 'h10, 'h22, 'h3F};
    int fn_pool[20] = '{'h20, 'h21, 'h22, 'h23, 'h24, 'h25, 'h26, 'h27, 'h2A, 'h2B,
                        'h04, 'h06, 'h07, 'h00, 'h02, 'h03, 'h08, 'h09, 'h05, 'h3F};

    initial begin
        errors = 0;
        checks = 0;
        Reset  = 1'b1;
        Instr  = 32'h0;
        repeat (2) @(posedge Clk);
        #1;
        check("reset_nop", {A1, A2, A3, ic}, pack(0, 0, 0, 0));
        @(negedge Clk);
        Reset = 1'b0;

        apply_check("addu", 32'h0022_1821, pack(1, 2, 3, 1));
        apply_check("sll",  32'h0003_1080, pack(0, 3, 2, 1));
        apply_check("ori",  32'h3485_0010, pack(4, 0, 5, 2));
        apply_check("lui",  32'h3C07_0001, pack(0, 0, 7, 2));
        apply_check("lw",   32'h8D28_0004, pack(9, 0, 8, 3));
        apply_check("sw",   32'hAD28_0000, pack(9, 8, 0, 4));
        apply_check("beq",  32'h1022_0003, pack(1, 2, 0, 5));
        apply_check("bgtz", 32'h1C60_0002, pack(3, 0, 0, 5));
        apply_check("jr",   32'h03E0_0008, pack(31, 0, 0, 6));
        apply_check("jal",  32'h0C00_0100, pack(0, 0, 31, 7));
        apply_check("jalr", 32'h0080_F809, pack(4, 0, 31, 8));
        apply_check("nop",  32'h0000_0000, pack(0, 0, 0, 0));
        apply_check("j",    32'h0800_0100, pack(0, 0, 0, 0));
        apply_check("undef", 32'hFC00_0000, pack(0, 0, 0, 0));
        apply_check("bgez",  32'h0461_0004, pack(3, 0, 0, 5));
        apply_check("regimm_rt2", 32'h0462_0004, pack(0, 0, 0, 0));
        apply_check("sll_nonzero", 32'h0000_0040, pack(0, 0, 0, 1));

        // Outputs must ignore Reset and clock edges.
        @(negedge Clk);
        Instr = 32'h0022_1821;
        Reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge Clk);
            #1;
            check("reset_hold_pos", {A1, A2, A3, ic}, pack(1, 2, 3, 1));
            @(negedge Clk);
            #1;
            check("reset_hold_neg", {A1, A2, A3, ic}, pack(1, 2, 3, 1));
        end
        Reset = 1'b0;
        @(posedge Clk);
        #1;
        check("reset_release", {A1, A2, A3, ic}, pack(1, 2, 3, 1));

        for (int n = 0; n < 3000; n++) begin
            logic [31:0] w;
            int op;
            w = $urandom;
            if ($urandom_range(0, 9) != 0) begin
                op = op_pool[$urandom_range(0, 29)];
                w[31:26] = op[5:0];
                if ($urandom_range(0, 2) != 0) begin
                    int fn;
                    fn = fn_pool[$urandom_range(0, 19)];
                    w[5:0] = fn[5:0];
                end
                if (op == 'h01 && $urandom_range(0, 1) == 1) w[20:16] = 5'($urandom_range(0, 3));
            end
            if ($urandom_range(0, 99) == 0) w = 32'h0;
            Reset = ($urandom_range(0, 7) == 0);
            apply_check("random", w, ref_decode(w));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/at_decoder.md
# at_decoder

Combinational register-address and hazard-class decoder for the five-stage MIPS pipeline. It takes the 32-bit instruction in Decode and produces the source register numbers (A1, A2), the destination register number (A3) and a 4-bit instruction class (ic). The hazard unit uses these outputs for stall and forwarding decisions, pipelining A1–A3 and ic through the E, M and W stages itself.

## Interface

- No parameters.
- Clk     input   1   clock. Present for interface uniformity; the block holds no state.
- Reset   input   1   reset, synchronous, active-high. Has no effect on outputs because the block is stateless.
- Instr   input   32  instruction word in Decode.
- A1      output  5   first source register (rs), or 0 if none is read.
- A2      output  5   second source register (rt), or 0 if none is read.
- A3      output  5   destination register, or 0 if none is written.
- ic      output  4   hazard class: 0 none, 1 cal_r, 2 cal_i, 3 load, 4 store, 5 b, 6 jr, 7 jal, 8 jalr. Codes 9–15 are unused.

## Operation

- Field mapping: op = Instr[31:26], rs = [25:21], rt = [20:16], rd = [15:11], funct = [5:0].
- Every unlisted output for a class is 0. Register 0 is never reported as a real dependency; the consumer masks it.
- cal_r (op 0):
  - funct 20, 21, 22, 23, 24, 25, 26, 27, 2A, 2B, 04, 06, 07 (add, addu, sub, subu, and, or, xor, nor, slt, sltu, sllv, srlv, srav): A1=rs, A2=rt, A3=rd.
  - funct 00, 02, 03 (sll, srl, sra): A1=0, A2=rt, A3=rd.
- cal_i:
  - op 08, 09, 0A, 0B, 0C, 0D, 0E: A1=rs, A3=rt.
  - op 0F (lui): A1=0, A3=rt.
- load (op 20, 21, 23, 24, 25): A1=rs, A3=rt.
- store (op 28, 29, 2B): A1=rs, A2=rt, A3=0.
- b:
  - op 04, 05: A1=rs, A2=rt.
  - op 06, 07, and op 01 with rt 0 or 1: A1=rs, A2=0.
  - A3=0 for all branches.
- jr (op 0, funct 08): A1=rs only.
- jal (op 03): A3=31, A1=A2=0.
- jalr (op 0, funct 09): A1=rs, A3=rd.
- Instr == 0x00000000 (nop), j (op 02), any other op/funct, and op 01 with other rt values: ic=0, A1=A2=A3=0.
- All decode decisions are full-width equality compares; outputs never contain X or Z for any input.

## Timing

- Purely combinational. Outputs settle in the same cycle Instr changes, with zero-cycle latency.
- No registers inside; nothing to reset. Outputs during and after Reset are a function of Instr only.
- Clk edges have no effect on outputs.
- The longest path is the op/funct compare feeding the output mux. It must close within the Decode-stage budget together with the hazard unit's comparators.

## Test plan

- 0x00221821 (addu $3,$1,$2) -> A1=1, A2=2, A3=3, ic=1. Also 0x00031080 (sll $2,$3,2) -> A1=0, A2=3, A3=2, ic=1.
- 0x34850010 (ori $5,$4,0x10) -> A1=4, A2=0, A3=5, ic=2. Also 0x3C070001 (lui $7) -> A1=0, A3=7, ic=2.
- 0x8D280004 (lw $8,4($9)) -> A1=9, A2=0, A3=8, ic=3. Also 0xAD280000 (sw $8,0($9)) -> A1=9, A2=8, A3=0, ic=4.
- 0x10220003 (beq $1,$2) -> A1=1, A2=2, A3=0, ic=5. Also 0x1C600002 (bgtz $3) -> A1=3, A2=0, ic=5.
- 0x03E00008 (jr $31) -> A1=31, ic=6. 0x0C000100 (jal) -> A3=31, ic=7. 0x0080F809 (jalr $31,$4) -> A1=4, A3=31, ic=8.
- 0x00000000, 0x08000100 (j), 0xFC000000 (undefined) -> all outputs 0. Toggle Reset and Clk with Instr held at 0x00221821 -> outputs remain A1=1, A2=2, A3=3, ic=1.
